// File: rtl/wb_cmd_master_arb.sv
// Round-robin arbiter over NUM_CH command streams feeding one classic WISHBONE master
// with rty retry. Optional TXN abort timer is enabled by `define WBCMD_TIMEOUT_EN.
module wb_cmd_master_arb #(
  parameter int NUM_CH         = 2,
  parameter int WB_ADR_BITS    = 22,
  parameter int DATA_BITS      = 32,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_ni,
  input  logic [NUM_CH*(WB_ADR_BITS+2)-1:0]   cmd_addr_i,
  input  logic [NUM_CH*DATA_BITS-1:0]         cmd_data_i,
  input  logic [NUM_CH-1:0]                   cmd_valid_i,
  output logic [NUM_CH-1:0]                   cmd_ack_o,
  output logic [NUM_CH-1:0]                   rsp_valid_o,
  output logic [DATA_BITS-1:0]                rsp_data_o,
  output logic [1:0]                          rsp_status_o,
  output logic                                wb_cyc_o,
  output logic                                wb_stb_o,
  output logic                                wb_we_o,
  output logic [WB_ADR_BITS-1:0]              wb_adr_o,
  output logic [DATA_BITS-1:0]                wb_dat_o,
  output logic [DATA_BITS/8-1:0]              wb_sel_o,
  input  logic [DATA_BITS-1:0]                wb_dat_i,
  input  logic                                wb_ack_i,
  input  logic                                wb_err_i,
  input  logic                                wb_rty_i
);

  localparam int CW = WB_ADR_BITS + 2;
  localparam int SW = DATA_BITS / 8;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_TXN, S_RETRY, S_RESP} state_e;

  state_e                 state_q;
  logic [PW-1:0]          rr_q, gnt_q, gnt_d, rr_d;
  logic                   gnt_vld_d;
  logic [RW-1:0]          retry_q;
  logic                   read_q, rd_sel_d;
  logic [WB_ADR_BITS-1:0] adr_sel_d;
  logic [DATA_BITS-1:0]   dat_sel_d;
  logic [NUM_CH-1:0]      cmd_ack_q, rsp_valid_q;
  logic [DATA_BITS-1:0]   rsp_data_q, wb_dat_q;
  logic [1:0]             rsp_status_q;
  logic                   cyc_q, we_q;
  logic [WB_ADR_BITS-1:0] adr_q;
  logic [SW-1:0]          sel_q;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= NUM_CH) s = s - NUM_CH;
    return PW'(s);
  endfunction

  // First requester at or after the round-robin pointer.
  always_comb begin
    gnt_vld_d = 1'b0;
    gnt_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!gnt_vld_d && cmd_valid_i[wrap_add(rr_q, i)]) begin
        gnt_vld_d = 1'b1;
        gnt_d     = wrap_add(rr_q, i);
      end
    end
  end

  always_comb begin
    rr_d      = wrap_add(gnt_q, 1);
    rd_sel_d  = cmd_addr_i[int'(gnt_d)*CW + CW - 1];
    adr_sel_d = cmd_addr_i[int'(gnt_d)*CW +: WB_ADR_BITS];
    dat_sel_d = cmd_data_i[int'(gnt_d)*DATA_BITS +: DATA_BITS];
  end

`ifdef WBCMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      retry_q      <= '0;
      read_q       <= 1'b0;
      cmd_ack_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_status_q <= 2'b00;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      wb_dat_q     <= '0;
      sel_q        <= '0;
`ifdef WBCMD_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      cmd_ack_q   <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld_d) begin
            gnt_q            <= gnt_d;
            read_q           <= rd_sel_d;
            we_q             <= !rd_sel_d;
            sel_q            <= rd_sel_d ? '0 : '1;
            adr_q            <= adr_sel_d;
            wb_dat_q         <= dat_sel_d;
            cmd_ack_q[gnt_d] <= 1'b1;
            state_q          <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          rr_q    <= rr_d;
          cyc_q   <= 1'b1;
          state_q <= S_TXN;
        end
        S_TXN: begin
          if (wb_ack_i) begin
            rsp_data_q         <= read_q ? wb_dat_i : wb_dat_q;
            rsp_status_q       <= 2'b00;
            rsp_valid_q[gnt_q] <= 1'b1;
            cyc_q              <= 1'b0;
            state_q            <= S_RESP;
          end else if (wb_err_i) begin
            rsp_status_q       <= 2'b01;
            rsp_valid_q[gnt_q] <= 1'b1;
            cyc_q              <= 1'b0;
            state_q            <= S_RESP;
          end else if (wb_rty_i) begin
            cyc_q <= 1'b0;
            if (int'(retry_q) < MAX_RETRY) begin
              retry_q <= retry_q + RW'(1);
              state_q <= S_RETRY;
            end else begin
              rsp_status_q       <= 2'b10;
              rsp_valid_q[gnt_q] <= 1'b1;
              state_q            <= S_RESP;
            end
`ifdef WBCMD_TIMEOUT_EN
          end else if (tmo_q >= TW'(TIMEOUT_CYCLES - 1)) begin
            // Counter parks at TIMEOUT_CYCLES until RESP clears it.
            tmo_q              <= TW'(TIMEOUT_CYCLES);
            rsp_status_q       <= 2'b11;
            rsp_valid_q[gnt_q] <= 1'b1;
            cyc_q              <= 1'b0;
            state_q            <= S_RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
`endif
          end
        end
        S_RETRY: begin
`ifdef WBCMD_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          cyc_q   <= 1'b1;
          state_q <= S_TXN;
        end
        S_RESP: begin
          retry_q <= '0;
`ifdef WBCMD_TIMEOUT_EN
          tmo_q   <= '0;
`endif
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ack_o    = cmd_ack_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = wb_dat_q;
  assign wb_sel_o     = sel_q;

endmodule
